// File: rtl/block_ram_player_pkg.sv
// Shared types and RAM field layout for the block RAM stimulus player.
package block_ram_player_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StPlay  = 2'd2,
        StDone  = 2'd3
    } player_state_e;

    localparam int unsigned I_LSB = 0;
    localparam int unsigned Q_LSB = 8;

endpackage

// File: rtl/block_ram_player_sdp_bram.sv
// Simple dual-port, single-clock inferred block RAM with a registered read port.
module sdp_bram #(
    parameter int unsigned RAM_WIDTH       = 32,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter string       RAM_PERFORMANCE = "LOW_LATENCY",
    parameter string       INIT_FILE       = ""
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [$clog2(RAM_DEPTH)-1:0] i_wr_adrs,
    input  logic [RAM_WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(RAM_DEPTH)-1:0] i_rd_adrs,
    output logic [RAM_WIDTH-1:0]         o_rd_data
);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_adrs] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_adrs];
    end

    // HIGH_PERFORMANCE adds the BRAM output register: two cycles of read latency.
    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_out_reg
        logic [RAM_WIDTH-1:0] r_out;
        always_ff @(posedge clk) begin
            r_out <= r_rd_data;
        end
        assign o_rd_data = r_out;
    end else begin : g_no_out_reg
        assign o_rd_data = r_rd_data;
    end

    if (INIT_FILE != "") begin : g_init_unsupported
        $error("sdp_bram: INIT_FILE preload is not supported, contents come from the write port");
    end

endmodule

// File: rtl/block_ram_player.sv
// Plays I/Q words from a private block RAM as signed samples at the symbol-rate strobe.
module block_ram_player
    import block_ram_player_pkg::*;
#(
    parameter int unsigned NBT_I_EQLZR = 8,
    parameter int unsigned RAM_WIDTH   = 32,
    parameter int unsigned RAM_DEPTH   = 32768,
    parameter int unsigned NBT_LEN     = 16
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_load_we,
    input  logic [$clog2(RAM_DEPTH)-1:0] i_load_adrs,
    input  logic [RAM_WIDTH-1:0]         i_load_data,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_loop,
    input  logic [NBT_LEN-1:0]           i_length,
    input  logic                         i_rate_en,
    output logic [NBT_I_EQLZR-1:0]       o_sample_I,
    output logic [NBT_I_EQLZR-1:0]       o_sample_Q,
    output logic                         o_sample_valid,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_load_err,
    output logic [NBT_LEN-1:0]           o_play_count
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
    // Length register must hold RAM_DEPTH itself, which needs one bit more than an address.
    localparam int unsigned CW = (AW + 1 > NBT_LEN) ? AW + 1 : NBT_LEN;

    player_state_e          r_state;
    logic [AW-1:0]          r_adrs;
    logic [CW-1:0]          r_len;
    logic                   r_loop;
    logic [NBT_I_EQLZR-1:0] r_sample_i;
    logic [NBT_I_EQLZR-1:0] r_sample_q;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_load_err;
    logic [NBT_LEN-1:0]     r_play_count;

    logic                   w_idle_like;
    logic                   w_start;
    logic                   w_fire;
    logic                   w_last;
    logic                   w_we;
    logic [AW-1:0]          w_next_adrs;
    logic [AW-1:0]          w_rd_adrs;
    logic [CW-1:0]          w_len_in;
    logic [RAM_WIDTH-1:0]   w_rd_data;
    logic                   w_unused_rsvd;

    assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
    assign w_start     = w_idle_like && i_start && !i_stop && (i_length != '0);
    assign w_fire      = (r_state == StPlay) && i_rate_en && !i_stop;
    assign w_last      = (CW'(r_adrs) == (r_len - CW'(1)));
    assign w_next_adrs = w_last ? '0 : r_adrs + AW'(1);
    assign w_len_in    = (CW'(i_length) > CW'(RAM_DEPTH)) ? CW'(RAM_DEPTH) : CW'(i_length);
    assign w_we        = i_load_we && w_idle_like;

    // Look ahead on a fire so the next word is already registered for a back-to-back strobe.
    assign w_rd_adrs = w_fire ? w_next_adrs : r_adrs;

    assign w_unused_rsvd = ^w_rd_data[RAM_WIDTH-1:Q_LSB+NBT_I_EQLZR];

    sdp_bram #(
        .RAM_WIDTH      (RAM_WIDTH),
        .RAM_DEPTH      (RAM_DEPTH),
        .RAM_PERFORMANCE("LOW_LATENCY"),
        .INIT_FILE      ("")
    ) u_sdp_bram (
        .clk      (clk),
        .i_we     (w_we),
        .i_wr_adrs(i_load_adrs),
        .i_wr_data(i_load_data),
        .i_rd_adrs(w_rd_adrs),
        .o_rd_data(w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_adrs       <= '0;
            r_len        <= '0;
            r_loop       <= 1'b0;
            r_sample_i   <= '0;
            r_sample_q   <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_err   <= 1'b0;
            r_play_count <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_load_we && !w_idle_like) begin
                r_load_err <= 1'b1;
            end
            if (i_stop) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle, StDone: begin
                        if (w_start) begin
                            r_state      <= StPrime;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_len        <= w_len_in;
                            r_loop       <= i_loop;
                            r_adrs       <= '0;
                            r_play_count <= '0;
                            r_load_err   <= 1'b0;
                        end
                    end
                    StPrime: begin
                        r_state <= StPlay;
                    end
                    StPlay: begin
                        if (i_rate_en) begin
                            r_valid      <= 1'b1;
                            r_sample_i   <= w_rd_data[I_LSB +: NBT_I_EQLZR];
                            r_sample_q   <= w_rd_data[Q_LSB +: NBT_I_EQLZR];
                            r_play_count <= r_play_count + NBT_LEN'(1);
                            r_adrs       <= w_next_adrs;
                            if (w_last && !r_loop) begin
                                r_state <= StDone;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_sample_I     = r_sample_i;
    assign o_sample_Q     = r_sample_q;
    assign o_sample_valid = r_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_load_err     = r_load_err;
    assign o_play_count   = r_play_count;

endmodule

// File: tb/tb_block_ram_player.sv
// Self-checking bench for block_ram_player against a word-index playback model.
module tb_block_ram_player;

    localparam int W     = 8;
    localparam int RW    = 32;
    localparam int DEPTH = 32768;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_load_we;
    logic [AW-1:0] i_load_adrs;
    logic [RW-1:0] i_load_data;
    logic          i_start;
    logic          i_stop;
    logic          i_loop;
    logic [LW-1:0] i_length;
    logic          i_rate_en;
    logic [W-1:0]  o_sample_I;
    logic [W-1:0]  o_sample_Q;
    logic          o_sample_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_load_err;
    logic [LW-1:0] o_play_count;

    int checks   = 0;
    int failures = 0;

    // Model: what the RAM should hold, and which addresses the bench has written.
    logic [RW-1:0] mem_model [DEPTH];
    bit            known     [DEPTH];
    logic [15:0]   last_s;

    always #5 clk = ~clk;

    block_ram_player dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_load_we     (i_load_we),
        .i_load_adrs   (i_load_adrs),
        .i_load_data   (i_load_data),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_loop        (i_loop),
        .i_length      (i_length),
        .i_rate_en     (i_rate_en),
        .o_sample_I    (o_sample_I),
        .o_sample_Q    (o_sample_Q),
        .o_sample_valid(o_sample_valid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_load_err    (o_load_err),
        .o_play_count  (o_play_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [RW-1:0] d);
        i_load_we   = 1'b1;
        i_load_adrs = AW'(a);
        i_load_data = d;
        step();
        i_load_we   = 1'b0;
        mem_model[a] = d;
        known[a]     = 1'b1;
    endtask

    // Leaves the bench one cycle after the start edge, i.e. during PRIME.
    task automatic start_play(input int len, input bit lp);
        i_start  = 1'b1;
        i_length = LW'(len);
        i_loop   = lp;
        step();
        i_start  = 1'b0;
        i_length = LW'($urandom_range(1, 65535));
        i_loop   = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_rate_en = 1'b1;
        step();
        step();
        checks++;
        if ({o_sample_I, o_sample_Q, o_sample_valid} !== 17'h0) begin
            failures++;
            $display("FAIL reset_samples got=%h want=0", {o_sample_I, o_sample_Q, o_sample_valid});
        end
        checks++;
        if ({o_busy, o_done, o_load_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {o_busy, o_done, o_load_err});
        end
        checks++;
        if (o_play_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", o_play_count);
        end
        i_reset = 1'b0;
        i_rate_en = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int got = 0;
        load_word(0, 32'h0000_1001);
        load_word(1, 32'h0000_2002);
        load_word(2, 32'h0000_3003);
        load_word(3, 32'h0000_FF80);
        for (int a = 4; a < 16; a++) load_word(a, $urandom);
        load_word(DEPTH - 1, $urandom);
        start_play(4, 1'b0);
        for (int c = 0; c < 60 && !o_done; c++) begin
            i_rate_en = (c % 4 == 3);
            step();
            if (o_sample_valid) begin
                checks++;
                if (got >= 4 || {o_sample_Q, o_sample_I} !== mem_model[got][15:0]) begin
                    failures++;
                    $display("FAIL basic_sample idx=%0d got=%h want=%h", got,
                             {o_sample_Q, o_sample_I}, mem_model[got % 4][15:0]);
                end
                got++;
            end
        end
        i_rate_en = 1'b0;
        checks++;
        if (got != 4) begin
            failures++;
            $display("FAIL basic_valid_count got=%0d want=4", got);
        end
        checks++;
        if ({o_done, o_busy} !== 2'b10 || o_play_count !== 16'd4) begin
            failures++;
            $display("FAIL basic_done got=done%b busy%b cnt%0d want=done1 busy0 cnt4",
                     o_done, o_busy, o_play_count);
        end
        step();
        checks++;
        if ($signed(o_sample_I) !== -8'sd128 || $signed(o_sample_Q) !== -8'sd1) begin
            failures++;
            $display("FAIL basic_last_hold got=(%0d,%0d) want=(-128,-1)",
                     $signed(o_sample_I), $signed(o_sample_Q));
        end
    endtask

    task automatic test_back_to_back();
        bit exp_valid;
        start_play(4, 1'b0);
        i_rate_en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            exp_valid = (c >= 1 && c <= 4);
            checks++;
            if (o_sample_valid !== exp_valid) begin
                failures++;
                $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c, o_sample_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if ({o_sample_Q, o_sample_I} !== mem_model[c-1][15:0]) begin
                    failures++;
                    $display("FAIL b2b_sample cycle=%0d got=%h want=%h", c,
                             {o_sample_Q, o_sample_I}, mem_model[c-1][15:0]);
                end
            end
        end
        i_rate_en = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_play_count !== 16'd4) begin
            failures++;
            $display("FAIL b2b_done got=done%b cnt%0d want=done1 cnt4", o_done, o_play_count);
        end
    endtask

    task automatic test_loop();
        int got = 0;
        start_play(3, 1'b1);
        for (int c = 0; c < 200 && got < 8; c++) begin
            i_rate_en = (c > 0) && ($urandom_range(0, 2) == 0);
            step();
            if (o_sample_valid) begin
                checks++;
                if ({o_sample_Q, o_sample_I} !== mem_model[got % 3][15:0]) begin
                    failures++;
                    $display("FAIL loop_sample idx=%0d got=%h want=%h", got,
                             {o_sample_Q, o_sample_I}, mem_model[got % 3][15:0]);
                end
                last_s = mem_model[got % 3][15:0];
                got++;
            end
        end
        i_rate_en = 1'b0;
        // A start while busy must not restart anything.
        i_start  = 1'b1;
        i_length = 16'd2;
        step();
        i_start  = 1'b0;
        checks++;
        if (got != 8 || o_play_count !== 16'd8) begin
            failures++;
            $display("FAIL loop_count got=%0d/%0d want=8", got, o_play_count);
        end
        checks++;
        if ({o_done, o_busy} !== 2'b01) begin
            failures++;
            $display("FAIL loop_flags got=done%b busy%b want=done0 busy1", o_done, o_busy);
        end
    endtask

    task automatic test_stop();
        i_stop    = 1'b1;
        i_rate_en = 1'b1;
        step();
        i_stop = 1'b0;
        checks++;
        if ({o_sample_valid, o_busy, o_done} !== 3'b000) begin
            failures++;
            $display("FAIL stop_flags got=%b want=000", {o_sample_valid, o_busy, o_done});
        end
        checks++;
        if ({o_sample_Q, o_sample_I} !== last_s) begin
            failures++;
            $display("FAIL stop_hold got=%h want=%h", {o_sample_Q, o_sample_I}, last_s);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (o_sample_valid !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL stop_idle cycle=%0d got=valid%b busy%b want=0 0",
                         c, o_sample_valid, o_busy);
            end
        end
        i_rate_en = 1'b0;
    endtask

    task automatic test_load_err();
        int got = 0;
        logic [RW-1:0] bad;
        load_word(5, $urandom);
        start_play(8, 1'b0);
        step();
        bad         = ~mem_model[5];
        i_load_we   = 1'b1;
        i_load_adrs = AW'(5);
        i_load_data = bad;
        step();
        i_load_we   = 1'b0;
        checks++;
        if (o_load_err !== 1'b1) begin
            failures++;
            $display("FAIL load_err_set got=%b want=1", o_load_err);
        end
        for (int c = 0; c < 200 && !o_done; c++) begin
            i_rate_en = 1'($urandom_range(0, 1));
            step();
            if (o_sample_valid) begin
                checks++;
                if (got >= 8 || {o_sample_Q, o_sample_I} !== mem_model[got][15:0]) begin
                    failures++;
                    $display("FAIL load_err_sample idx=%0d got=%h want=%h", got,
                             {o_sample_Q, o_sample_I}, mem_model[got % 8][15:0]);
                end
                got++;
            end
        end
        i_rate_en = 1'b0;
        checks++;
        if (got != 8 || o_load_err !== 1'b1) begin
            failures++;
            $display("FAIL load_err_play got=%0d err%b want=8 err1", got, o_load_err);
        end
        start_play(8, 1'b0);
        checks++;
        if (o_load_err !== 1'b0) begin
            failures++;
            $display("FAIL load_err_clear got=%b want=0", o_load_err);
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
    endtask

    task automatic test_len_zero();
        start_play(0, 1'b0);
        step();
        checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            failures++;
            $display("FAIL len0_idle got=busy%b done%b want=0 0", o_busy, o_done);
        end
        start_play(1, 1'b0);
        i_rate_en = 1'b1;
        step();
        step();
        i_rate_en = 1'b0;
        checks++;
        if ({o_sample_valid, o_done} !== 2'b11 || {o_sample_Q, o_sample_I} !== mem_model[0][15:0])
        begin
            failures++;
            $display("FAIL len1_play got=valid%b done%b %h want=1 1 %h", o_sample_valid, o_done,
                     {o_sample_Q, o_sample_I}, mem_model[0][15:0]);
        end
        start_play(0, 1'b0);
        step();
        checks++;
        if ({o_busy, o_done} !== 2'b01) begin
            failures++;
            $display("FAIL len0_done got=busy%b done%b want=0 1", o_busy, o_done);
        end
    endtask

    task automatic test_full_length();
        int got = 0;
        start_play(16'hFFFF, 1'b0);
        i_rate_en = 1'b1;
        for (int c = 0; c < 33000 && !o_done; c++) begin
            step();
            if (o_sample_valid) begin
                if (got < DEPTH && known[got]) begin
                    checks++;
                    if ({o_sample_Q, o_sample_I} !== mem_model[got][15:0]) begin
                        failures++;
                        $display("FAIL full_sample idx=%0d got=%h want=%h", got,
                                 {o_sample_Q, o_sample_I}, mem_model[got][15:0]);
                    end
                end
                got++;
            end
        end
        i_rate_en = 1'b0;
        checks++;
        if (got != DEPTH || o_done !== 1'b1 || o_play_count !== 16'h8000) begin
            failures++;
            $display("FAIL full_length got=%0d done%b cnt%0d want=32768 done1 cnt32768",
                     got, o_done, o_play_count);
        end
    endtask

    task automatic test_reset_mid_play();
        start_play(4, 1'b1);
        i_rate_en = 1'b1;
        step();
        step();
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        checks++;
        if ({o_sample_I, o_sample_Q, o_sample_valid, o_busy, o_done, o_load_err} !== 20'h0 ||
            o_play_count !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h cnt%0d want=0", {o_sample_I, o_sample_Q,
                     o_sample_valid, o_busy, o_done, o_load_err}, o_play_count);
        end
        step();
        checks++;
        if (o_sample_valid !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_quiet got=valid%b busy%b want=0 0", o_sample_valid, o_busy);
        end
        i_rate_en = 1'b0;
        start_play(4, 1'b0);
        i_rate_en = 1'b1;
        step();
        step();
        i_rate_en = 1'b0;
        checks++;
        if (o_sample_valid !== 1'b1 || {o_sample_Q, o_sample_I} !== mem_model[0][15:0]) begin
            failures++;
            $display("FAIL rst_mid_replay got=valid%b %h want=1 %h", o_sample_valid,
                     {o_sample_Q, o_sample_I}, mem_model[0][15:0]);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset     = 1'b1;
        i_load_we   = 1'b0;
        i_load_adrs = '0;
        i_load_data = '0;
        i_start     = 1'b0;
        i_stop      = 1'b0;
        i_loop      = 1'b0;
        i_length    = '0;
        i_rate_en   = 1'b0;
        last_s      = '0;
        for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_loop();
        test_stop();
        test_load_err();
        test_len_zero();
        test_full_length();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_ram_player.md
Name: block_ram_player

Overview:
- Stimulus-injection counterpart of the sample logger (block_ram_control). Logging runs system to RAM to MicroBlaze; this block runs the other way, MicroBlaze to RAM to system.
- The reg_file loads I/Q words from MicroBlaze GPIO writes into a private block RAM.
- On command, the block plays the words back as signed I/Q samples at the system symbol-rate strobe. It feeds the equalizer input path in place of the channel samples.

Parameters:
- NBT_I_EQLZR, 8, width of each played sample (I and Q).
- RAM_WIDTH, 32, RAM word width; bits [7:0] hold I, bits [15:8] hold Q, bits [31:16] are reserved and ignored.
- RAM_DEPTH, 32768, number of words; address width is $clog2(RAM_DEPTH).
- NBT_LEN, 16, width of the length and play-count fields.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_load_we  in  1  one-cycle write strobe from reg_file.
- i_load_adrs  in  $clog2(RAM_DEPTH)  write address.
- i_load_data  in  RAM_WIDTH  write data.
- i_start  in  1  start playback (level sampled each cycle).
- i_stop  in  1  abort playback.
- i_loop  in  1  wrap at end of block instead of finishing; sampled at start.
- i_length  in  NBT_LEN  number of words to play; sampled at start.
- i_rate_en  in  1  sample strobe (i_control_for_rate_x).
- o_sample_I  out  NBT_I_EQLZR  signed I sample.
- o_sample_Q  out  NBT_I_EQLZR  signed Q sample.
- o_sample_valid  out  1  one-cycle qualifier for o_sample_I/Q.
- o_busy  out  1  high in PRIME or PLAY.
- o_done  out  1  high in DONE.
- o_load_err  out  1  sticky flag: a write was dropped.
- o_play_count  out  NBT_LEN  samples emitted since the last start.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; the read address is 0. RAM contents are not cleared.
- FSM states: IDLE, PRIME, PLAY, DONE.
- Start, IDLE or DONE to PRIME: taken when i_start=1, i_stop=0 and i_length!=0.
  - Latch len = min(i_length, RAM_DEPTH) and loop = i_loop.
  - Clear o_play_count, o_done and o_load_err.
  - Read address is 0.
- i_start with i_length=0: ignored; the state is unchanged.
- i_start while busy: ignored.
- PRIME lasts exactly 1 cycle: it issues the read of address 0, then goes to PLAY. i_rate_en is ignored in PRIME.
- RAM read latency is 1 cycle and registered (LOW_LATENCY).
  - The read address presented to the RAM is the next address when a fire occurs that cycle, else the current one.
  - This makes back-to-back i_rate_en produce consecutive words with no bubble.
- PLAY, fire (i_rate_en=1):
  - Next edge: o_sample_I/Q take the current RAM word; o_sample_valid=1 for 1 cycle; o_play_count increments (wraps mod 2^NBT_LEN); the address advances.
  - Latency is 1 cycle from i_rate_en to o_sample_valid.
- End of block, the fire on word index len-1:
  - loop=1: the address wraps to 0 and playback continues without a gap.
  - loop=0: that sample is emitted, then the FSM goes to DONE with o_done=1.
- DONE holds until i_start, i_stop or reset.
- o_sample_I/Q hold their last value between valids and in IDLE/DONE. They are cleared only by reset.
- i_stop in any state: IDLE on the next edge, and o_sample_valid=0 that cycle. A fire in the same cycle as i_stop is discarded. i_stop has priority over i_start.
- Writes:
  - i_load_we in IDLE or DONE writes mem[i_load_adrs] = i_load_data.
  - i_load_we while o_busy drops the write and sets o_load_err.
- Reset mid-playback: IDLE next edge, outputs 0, and no further o_sample_valid.

Decomposition:
- Shared package holds:
  - the FSM state encoding constants (IDLE=0, PRIME=1, PLAY=2, DONE=3);
  - the RAM field offsets (I_LSB=0, Q_LSB=8).
- One sub-module: sdp_bram, a simple dual-port single-clock inferred RAM.
  - Parameters: RAM_WIDTH, RAM_DEPTH, RAM_PERFORMANCE, INIT_FILE.
  - Write port driven from the load interface; registered read port.
- FSM, address counter, length compare and play counter live in block_ram_player.

Test Plan:
- Load words 0..3 = 0x0000_1001, 0x0000_2002, 0x0000_3003, 0x0000_FF80. Then i_length=4, loop=0, start, i_rate_en every 4th cycle -> 4 valids with (I,Q) = (1,16), (2,32), (3,48), (-128,-1). Then o_done=1 and o_play_count=4.
- Same data with i_rate_en held high continuously -> 4 consecutive-cycle valids with no bubble. The first valid comes 1 cycle after the first fire in PLAY.
- loop=1, i_length=3, 8 fires -> sequence (I) 1,2,3,1,2,3,1,2; o_done stays 0; o_play_count=8.
- Mid-play i_stop asserted together with i_rate_en -> no valid that cycle, IDLE next cycle, o_busy=0, outputs hold the last sample.
- i_load_we to address 5 during PLAY -> o_load_err=1 and mem[5] unchanged (read back by replay). Next i_start clears o_load_err.
- i_length=0 start -> stays IDLE. i_length=0xFFFF with RAM_DEPTH=32768 -> done after 32768 samples.
- i_reset during PLAY -> all outputs 0 next edge. A following start replays from address 0.
